// File: rtl/image_pipe_pkg.sv
// Purpose: shared types and widths for the image-pipe arbiter family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package image_pipe_pkg;

    // ARB: choosing the next frame owner; LOCK: one owner streams until its end beat.
    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Purpose: round-robin first-one finder; scans i_req from i_start upward, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: i_req request vector, i_start scan origin, o_idx winning index, o_found any request set.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    always_comb begin
        int w_j;
        o_idx   = '0;
        o_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(i_start) + k) % N;
            // Only the first hit in scan order wins.
            if (!o_found && i_req[w_j]) begin
                o_found = 1'b1;
                o_idx   = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/image_pipe_arb.sv
// Purpose: frame-granular round-robin arbiter sharing one image pipe port among N streams.
// Latency: zero-latency mux in LOCK; one ARB cycle per frame between end beat and next first beat.
// Backpressure: im_busy_in reaches only the owner's is_busy_out; all others see busy=1.
// Ports: cfg_* arbitration control, is_* requester streams, im_* pipe side,
//        grant_active/grant_idx ownership status, frame_cnt completed-frame counter.
module image_pipe_arb
    import image_pipe_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int DW = 32,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_enable,
    input  logic [N-1:0]           cfg_mask,
    input  logic [N*DW-1:0]        is_data_in,
    input  logic [N-1:0]           is_valid_in,
    input  logic [N-1:0]           is_end_in,
    output logic [N-1:0]           is_busy_out,
    output logic [DW-1:0]          im_data_out,
    output logic                   im_valid_out,
    output logic                   im_end_out,
    input  logic                   im_busy_in,
    output logic                   grant_active,
    output logic [IW-1:0]          grant_idx,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    arb_state_e             r_state;
    logic [IW-1:0]          r_grant_idx;
    logic [IW-1:0]          r_rr_ptr;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    logic [N-1:0]  w_req;
    logic [IW-1:0] w_pick_idx;
    logic          w_pick_found;
    logic          w_own_vld;
    logic          w_own_end;
    logic          w_end_xfer;

    // Enable gates every request, so a disabled block never leaves ARB.
    assign w_req = is_valid_in & ~cfg_mask & {N{cfg_enable}};

    rr_pick #(.N(N)) u_rr_pick (
        .i_req   (w_req),
        .i_start (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_own_vld  = is_valid_in[r_grant_idx];
    assign w_own_end  = is_end_in[r_grant_idx];
    // The end beat only counts once the pipe actually takes it.
    assign w_end_xfer = (r_state == LOCK) && w_own_vld && w_own_end && !im_busy_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ARB;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_pick_found) begin
                        r_grant_idx <= w_pick_idx;
                        r_state     <= LOCK;
                    end
                end
                LOCK: begin
                    if (w_end_xfer) begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        r_rr_ptr    <= (r_grant_idx == IW'(N - 1)) ? '0 : r_grant_idx + 1'b1;
                        r_state     <= ARB;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    // Data follows the current/last owner; it is only meaningful while im_valid_out is high.
    assign im_data_out = is_data_in[int'(r_grant_idx) * DW +: DW];

    always_comb begin
        is_busy_out  = '1;
        im_valid_out = 1'b0;
        im_end_out   = 1'b0;
        if (r_state == LOCK) begin
            im_valid_out             = w_own_vld;
            im_end_out               = w_own_vld & w_own_end;
            is_busy_out[r_grant_idx] = im_busy_in;
        end
    end

    assign grant_active = (r_state == LOCK);
    assign grant_idx    = r_grant_idx;
    assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_image_pipe_arb.sv
// Purpose: directed + randomized self-checking bench for image_pipe_arb (N=4, DW=32).
// Latency: inputs driven 1 ns after the rising edge, outputs sampled 1 ns later.
// Backpressure: im_busy_in driven directly and randomly; sources advance only on accepted beats.
module tb_image_pipe_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_enable;
    logic [N-1:0]    cfg_mask;
    logic [N*DW-1:0] din;
    logic [N-1:0]    vld;
    logic [N-1:0]    eop;
    logic [N-1:0]    busy_o;
    logic [DW-1:0]   im_data;
    logic            im_valid;
    logic            im_end;
    logic            im_busy;
    logic            gact;
    logic [IW-1:0]   gidx;
    logic [15:0]     fcnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state for the randomized phase.
    int          m_owner;
    int          m_ptr;
    logic [15:0] m_frames;
    int          pick;
    logic [N-1:0] exp_busy;
    int          beat [N];
    int          len  [N];
    int          fr   [N];

    always #5 clk = ~clk;

    image_pipe_arb #(.N(N), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_enable   (cfg_enable),
        .cfg_mask     (cfg_mask),
        .is_data_in   (din),
        .is_valid_in  (vld),
        .is_end_in    (eop),
        .is_busy_out  (busy_o),
        .im_data_out  (im_data),
        .im_valid_out (im_valid),
        .im_end_out   (im_end),
        .im_busy_in   (im_busy),
        .grant_active (gact),
        .grant_idx    (gidx),
        .frame_cnt    (fcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int i, input logic [31:0] d, input logic e);
        vld[i] = 1'b1;
        eop[i] = e;
        din[i*DW +: DW] = d;
    endtask

    task automatic clear();
        vld = '0;
        eop = '0;
    endtask

    initial begin
        rst = 1'b1; cfg_enable = 1'b1; cfg_mask = '0; din = '0;
        vld = '0; eop = '0; im_busy = 1'b0;

        // ---------------- reset state ----------------
        cyc(); cyc(); #1;
        chk("rst_gact", 32'(gact), 32'd0);
        chk("rst_gidx", 32'(gidx), 32'd0);
        chk("rst_fcnt", 32'(fcnt), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'hF);
        chk("rst_valid", 32'(im_valid), 32'd0);
        chk("rst_end", 32'(im_end), 32'd0);
        rst = 1'b0;

        // ---------------- single 3-beat frame from requester 2 ----------------
        set_beat(2, 32'hA0A0_0001, 1'b0); #1;
        chk("t1_arb_valid", 32'(im_valid), 32'd0);
        chk("t1_arb_busy", 32'(busy_o), 32'hF);
        cyc(); #1;
        chk("t1_gact", 32'(gact), 32'd1);
        chk("t1_gidx", 32'(gidx), 32'd2);
        chk("t1_b1_data", im_data, 32'hA0A0_0001);
        chk("t1_b1_end", 32'(im_end), 32'd0);
        chk("t1_busy", 32'(busy_o), 32'b1011);
        cyc(); set_beat(2, 32'hA0A0_0002, 1'b0); #1;
        chk("t1_b2_valid", 32'(im_valid), 32'd1);
        chk("t1_b2_data", im_data, 32'hA0A0_0002);
        cyc(); set_beat(2, 32'hA0A0_0003, 1'b1); #1;
        chk("t1_b3_data", im_data, 32'hA0A0_0003);
        chk("t1_b3_end", 32'(im_end), 32'd1);
        cyc(); clear(); #1;
        chk("t1_done_gact", 32'(gact), 32'd0);
        chk("t1_fcnt", 32'(fcnt), 32'd1);

        // ---------------- reset in the 2nd beat of a 4-beat frame ----------------
        set_beat(3, 32'hD0D0_0000, 1'b0); #1;
        cyc(); #1;
        chk("t5_gidx", 32'(gidx), 32'd3);
        cyc(); set_beat(3, 32'hD0D0_0001, 1'b0); rst = 1'b1; #1;
        chk("t5_b2_valid", 32'(im_valid), 32'd1);
        cyc(); #1;
        chk("t5_valid", 32'(im_valid), 32'd0);
        chk("t5_busy", 32'(busy_o), 32'hF);
        chk("t5_fcnt", 32'(fcnt), 32'd0);
        chk("t5_gact", 32'(gact), 32'd0);
        rst = 1'b0; clear();

        // ---------------- round robin, all requesters, 1-beat frames ----------------
        for (int i = 0; i < N; i++) set_beat(i, 32'h100 + 32'(i), 1'b1);
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k % 2 == 1) begin
                chk("rr_gidx", 32'(gidx), 32'(((k - 1) / 2) % N));
                chk("rr_valid", 32'(im_valid), 32'd1);
                chk("rr_end", 32'(im_end), 32'd1);
                chk("rr_data", im_data, 32'h100 + 32'(((k - 1) / 2) % N));
                chk("rr_busy", 32'(busy_o), 32'(~(4'b0001 << (((k - 1) / 2) % N)) & 4'hF));
            end else begin
                chk("rr_gap_gact", 32'(gact), 32'd0);
                chk("rr_gap_valid", 32'(im_valid), 32'd0);
            end
            cyc();
        end
        clear(); #1;
        chk("rr_fcnt", 32'(fcnt), 32'd5);

        // ---------------- back-pressure on the end beat ----------------
        set_beat(1, 32'hE000_0000, 1'b0);
        set_beat(0, 32'h0BAD_0000, 1'b0);
        set_beat(3, 32'h0BAD_0003, 1'b0); #1;
        cyc(); #1;
        chk("bp_gidx", 32'(gidx), 32'd1);
        chk("bp_busy0", 32'(busy_o), 32'b1101);
        cyc(); set_beat(1, 32'hE000_0001, 1'b1); im_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_hold_gact", 32'(gact), 32'd1);
            chk("bp_hold_end", 32'(im_end), 32'd1);
            chk("bp_hold_data", im_data, 32'hE000_0001);
            chk("bp_hold_busy", 32'(busy_o), 32'hF);
            chk("bp_hold_fcnt", 32'(fcnt), 32'd5);
            cyc();
        end
        im_busy = 1'b0; #1;
        chk("bp_release_busy", 32'(busy_o), 32'b1101);
        cyc(); clear(); #1;
        chk("bp_done_gact", 32'(gact), 32'd0);
        chk("bp_fcnt", 32'(fcnt), 32'd6);

        // ---------------- mask and enable ----------------
        cfg_mask = 4'b0010;
        set_beat(1, 32'h1111_0000, 1'b1);
        set_beat(3, 32'h3333_0000, 1'b1); #1;
        cyc(); #1;
        chk("mk_gidx_a", 32'(gidx), 32'd3);
        cyc(); #1;
        chk("mk_gap_gact", 32'(gact), 32'd0);
        chk("mk_fcnt_a", 32'(fcnt), 32'd7);
        set_beat(3, 32'h3333_0001, 1'b0); #1;
        cyc(); #1;
        // Pointer sits at 0 now, so an unmasked requester 1 would have won.
        chk("mk_gidx_b", 32'(gidx), 32'd3);
        cyc(); set_beat(3, 32'h3333_0002, 1'b0); cfg_enable = 1'b0; cfg_mask = '0; #1;
        chk("en_mid_gact", 32'(gact), 32'd1);
        chk("en_mid_gidx", 32'(gidx), 32'd3);
        chk("en_mid_valid", 32'(im_valid), 32'd1);
        cyc(); set_beat(3, 32'h3333_0003, 1'b1); #1;
        chk("en_last_end", 32'(im_end), 32'd1);
        cyc(); #1;
        chk("en_fcnt", 32'(fcnt), 32'd8);
        for (int k = 0; k < 3; k++) begin
            chk("en_off_gact", 32'(gact), 32'd0);
            chk("en_off_valid", 32'(im_valid), 32'd0);
            cyc(); #1;
        end
        clear(); cfg_enable = 1'b1;

        // ---------------- frame counter wrap ----------------
        @(negedge clk);
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_cnt;
        cyc(); #1;
        chk("wrap_preload", 32'(fcnt), 32'hFFFF);
        set_beat(0, 32'h0000_0FFF, 1'b1); #1;
        cyc(); #1;
        chk("wrap_gidx", 32'(gidx), 32'd0);
        cyc(); clear(); #1;
        chk("wrap_fcnt", 32'(fcnt), 32'd0);

        // ---------------- randomized traffic vs reference model ----------------
        rst = 1'b1; clear(); cfg_mask = '0; cfg_enable = 1'b1; im_busy = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        m_owner = -1; m_ptr = 0; m_frames = '0;
        for (int i = 0; i < N; i++) begin
            beat[i] = 0; fr[i] = 0; len[i] = $urandom_range(1, 4);
        end
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                vld[i] = ($urandom_range(0, 9) < 7);
                eop[i] = (beat[i] == len[i] - 1);
                din[i*DW +: DW] = {8'(i), 8'(fr[i]), 16'(beat[i])};
            end
            im_busy    = ($urandom_range(0, 9) < 3);
            cfg_enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) cfg_mask = 4'($urandom_range(0, 15));
            #1;

            exp_busy = '1;
            if (m_owner >= 0) exp_busy[m_owner] = im_busy;
            chk("rnd_fcnt", 32'(fcnt), 32'(m_frames));
            chk("rnd_busy", 32'(busy_o), 32'(exp_busy));
            if (m_owner < 0) begin
                chk("rnd_arb_gact", 32'(gact), 32'd0);
                chk("rnd_arb_valid", 32'(im_valid), 32'd0);
                chk("rnd_arb_end", 32'(im_end), 32'd0);
            end else begin
                chk("rnd_gact", 32'(gact), 32'd1);
                chk("rnd_gidx", 32'(gidx), 32'(m_owner));
                chk("rnd_valid", 32'(im_valid), 32'(vld[m_owner]));
                chk("rnd_end", 32'(im_end), 32'(vld[m_owner] & eop[m_owner]));
                if (vld[m_owner])
                    chk("rnd_data", im_data, {8'(m_owner), 8'(fr[m_owner]), 16'(beat[m_owner])});
            end

            // Ownership rules: a free port goes to the first eligible requester from the
            // pointer; an owner keeps it until its end beat is taken.
            if (m_owner < 0) begin
                pick = -1;
                for (int k = 0; k < N; k++)
                    if (pick < 0 && cfg_enable && vld[(m_ptr + k) % N] && !cfg_mask[(m_ptr + k) % N])
                        pick = (m_ptr + k) % N;
                m_owner = pick;
            end else if (vld[m_owner] && eop[m_owner] && !im_busy) begin
                m_frames = m_frames + 16'd1;
                m_ptr    = (m_owner + 1) % N;
                m_owner  = -1;
            end

            for (int i = 0; i < N; i++) begin
                if (vld[i] && !exp_busy[i]) begin
                    if (eop[i]) begin
                        beat[i] = 0;
                        fr[i]   = fr[i] + 1;
                        len[i]  = $urandom_range(1, 4);
                    end else begin
                        beat[i] = beat[i] + 1;
                    end
                end
            end
            cyc();
        end
        #1;
        chk("rnd_final_fcnt", 32'(fcnt), 32'(m_frames));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
